dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Multi-cycle data-memory responder on the target side of the pipeline's MEM-stage load/store interface.
- Accepts one load/store request at a time, holds the pipeline with `stall` while the access is in flight, then returns read data with a one-cycle `rsp_valid` pulse.
- Replaces the single-cycle combinational data memory so the core can be run against realistic memory latency.

Parameters:
- DATA_W, 32: data word width in bits.
- ADDR_W, 32: byte-address width in bits.
- DEPTH, 256: number of words in storage; must be a power of 2.
- LATENCY, 2: number of BUSY cycles per access; minimum 1.

Ports:
- clk  input  1  system clock; all logic is rising-edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  MEM stage holds a load or store (MemRead_m | MemWrite_m).
- req_write  input  1  1 = store, 0 = load.
- req_addr  input  ADDR_W  byte address (ALU result from EX/MEM).
- req_wdata  input  DATA_W  store data.
- req_ready  output  1  responder is idle and can accept a request.
- rsp_valid  output  1  one-cycle pulse: access complete.
- rsp_rdata  output  DATA_W  load data; valid when rsp_valid=1.
- rsp_err  output  1  misaligned-access flag (see Optional Feature).
- stall  output  1  freeze PC, IF/ID, ID/EX and EX/MEM.

Behaviour:
- Reset (synchronous, active-high, one clk edge):
  - state=IDLE, counter=0.
  - All DEPTH words cleared to 0.
  - req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, stall=0.
- Word index = req_addr[log2(DEPTH)+1:2]. Upper bits are ignored, so the index wraps modulo DEPTH. Bits [1:0] are ignored unless DMEM_MISALIGN_EN is defined.
- FSM states:
  - IDLE:
    - req_ready=1.
    - If req_valid: latch write, index and wdata; counter=LATENCY-1; go to BUSY.
  - BUSY:
    - req_ready=0.
    - If counter!=0: counter decrements.
    - If counter==0: perform the access, then go to DONE.
      - Store: word[index] <= wdata.
      - Load: rsp_rdata <= word[index].
  - DONE:
    - rsp_valid=1 for exactly this cycle; go to IDLE.
    - req_ready=0; a request presented here is not accepted.
- stall = (state==IDLE && req_valid) || state==BUSY. stall is combinational and low in DONE so the pipeline advances that cycle.
- Latency: a request accepted at cycle T has rsp_valid at T+LATENCY+1. stall is high for LATENCY+1 cycles.
- rsp_rdata holds its last load value until the next load completes. It is not updated by stores.
- Store response: rsp_valid is pulsed; rsp_rdata is unchanged.
- Back-to-back requests: a new request is accepted in the IDLE cycle after DONE. A load to the same index returns the just-stored data.
- req_valid dropping while BUSY: the latched request still completes. Inputs are sampled only at acceptance.
- Reset mid-operation: the access is aborted and state returns to IDLE. A store not yet committed (commit happens in the last BUSY cycle) is discarded; the array is cleared in any case.
- Reset and req_valid in the same cycle: reset wins; no acceptance.

Optional Feature:
- Macro: DMEM_MISALIGN_EN.
- Defined:
  - req_addr[1:0]!=0 is still accepted and sequenced identically.
  - No array access occurs: no write, and rsp_rdata is set to 0.
  - rsp_err=1 together with rsp_valid for the DONE cycle.
- Undefined: bits [1:0] are ignored and rsp_err is tied 0.

Decomposition:
- Package dmem_pkg:
  - State encoding typedef: IDLE=2'b00, BUSY=2'b01, DONE=2'b10.
  - DATA_W default.
  - Function computing the index width (clog2 of DEPTH).
- Sub-module dmem_array: single-port DEPTH×DATA_W storage.
  - Synchronous write-enable.
  - Synchronous read into a registered output.
  - Synchronous reset clear.
- The FSM/counter wrapper instantiates dmem_array.

Test Plan:
- Reset then idle:
  - Assert reset 1 cycle with req_valid=0.
  - Expect req_ready=1, stall=0, rsp_valid=0, rsp_rdata=0.
  - A load of address 0x10 returns 0.
- Store timing:
  - Store 0xDEADBEEF to 0x20 at cycle T.
  - Expect stall=1 at T..T+2 and rsp_valid=1 only at T+3.
  - rsp_rdata unchanged.
- Store then load:
  - Load 0x20 immediately after the store.
  - Expect rsp_rdata=0xDEADBEEF at the load's DONE cycle.
- Index wrap:
  - Store 0x12345678 to 0x400 (index 0 for DEPTH=256).
  - Load 0x0; expect 0x12345678.
- Reset mid-access:
  - Store 0xAAAA5555 to 0x30; assert reset in the first BUSY cycle.
  - Expect state=IDLE next cycle, no rsp_valid.
  - A later load of 0x30 returns 0.
- Misaligned access, DMEM_MISALIGN_EN defined:
  - Load 0x22.
  - Expect rsp_valid=1, rsp_err=1, rsp_rdata=0; contents of 0x20 unchanged.

Source files
------------

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared state encoding, width defaults and index-width helper for dmem_responder
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } dmem_state_t;

    localparam int DMEM_DATA_W = 32;

    function automatic int dmem_idx_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - single-port DEPTH x DATA_W word storage, registered read, synchronous clear
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DATA_W = DMEM_DATA_W,
    parameter int DEPTH  = 256,
    parameter int IDX_W  = dmem_idx_w(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic              rd_clr,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rdata <= '0;
        end else begin
            if (wr_en) begin
                mem[idx] <= wdata;
            end
            // rdata only moves on a completed load (or a rejected access), so it holds across stores
            if (rd_clr) begin
                rdata <= '0;
            end else if (rd_en) begin
                rdata <= mem[idx];
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - multi-cycle load/store responder with pipeline stall; DMEM_MISALIGN_EN flags misaligned accesses
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DATA_W  = DMEM_DATA_W,
    parameter int ADDR_W  = 32,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              stall
);

    localparam int IDX_W = dmem_idx_w(DEPTH);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

    dmem_state_t       state;
    logic [CNT_W-1:0]  cnt;
    logic              lat_write;
    logic              lat_mis;
    logic [IDX_W-1:0]  lat_idx;
    logic [DATA_W-1:0] lat_wdata;
    logic              req_mis;
    logic              access;
    logic              unused_addr_bits;

`ifdef DMEM_MISALIGN_EN
    assign req_mis = |req_addr[1:0];
`else
    assign req_mis = 1'b0;
`endif

    assign unused_addr_bits = ^{req_addr[ADDR_W-1:IDX_W+2], req_addr[1:0]};

    // The access commits on the last BUSY cycle so the result is visible in DONE
    assign access = (state == BUSY) && (cnt == '0);
    assign stall  = ((state == IDLE) && req_valid) || (state == BUSY);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            lat_write <= 1'b0;
            lat_mis   <= 1'b0;
            lat_idx   <= '0;
            lat_wdata <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_write <= req_write;
                        lat_mis   <= req_mis;
                        lat_idx   <= req_addr[IDX_W+1:2];
                        lat_wdata <= req_wdata;
                        cnt       <= CNT_INIT;
                        req_ready <= 1'b0;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= lat_mis;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

    dmem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk    (clk),
        .reset  (reset),
        .wr_en  (access && lat_write && !lat_mis),
        .rd_en  (access && !lat_write && !lat_mis),
        .rd_clr (access && lat_mis),
        .idx    (lat_idx),
        .wdata  (lat_wdata),
        .rdata  (rsp_rdata)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench: timeline model checked every cycle plus literal expectations
module tb_dmem_responder;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 32;
    localparam int DEPTH   = 256;
    localparam int LATENCY = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              req_ready;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              stall;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dmem_responder #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .DEPTH   (DEPTH),
        .LATENCY (LATENCY)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .stall     (stall)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Model: a request accepted in cycle T is busy for T+1..T+LATENCY and responds at T+LATENCY+1
    logic [DATA_W-1:0] m_mem [DEPTH];
    logic [DATA_W-1:0] m_rdata = '0;
    logic [DATA_W-1:0] m_wdata;
    bit                m_pending = 1'b0;
    bit                m_write;
    bit                m_mis;
    int                m_idx;
    int                m_cyc = 0;
    int                m_done_at = 0;
    bit                chk_en = 1'b0;

    initial begin
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    end

    always @(negedge clk) begin
        bit busy, done, idle, exp_err;
        busy = m_pending && (m_cyc < m_done_at);
        done = m_pending && (m_cyc == m_done_at);
        idle = !busy && !done;
`ifdef DMEM_MISALIGN_EN
        exp_err = done && m_mis;
`else
        exp_err = 1'b0;
`endif
        if (chk_en) begin
            chk("cyc_req_ready", req_ready, idle);
            chk("cyc_stall", stall, busy || (idle && req_valid));
            chk("cyc_rsp_valid", rsp_valid, done);
            chk("cyc_rsp_err", rsp_err, exp_err);
            chk("cyc_rsp_rdata", rsp_rdata, m_rdata);
        end
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
            m_rdata   = '0;
            m_pending = 1'b0;
        end else begin
            if (busy && (m_cyc == m_done_at - 1)) begin
                if (m_mis) m_rdata = '0;
                else if (m_write) m_mem[m_idx] = m_wdata;
                else m_rdata = m_mem[m_idx];
            end
            if (done) m_pending = 1'b0;
            if (idle && req_valid) begin
                m_pending = 1'b1;
                m_done_at = m_cyc + LATENCY + 1;
                m_write   = req_write;
                m_idx     = int'((req_addr >> 2) % DEPTH);
                m_wdata   = req_wdata;
`ifdef DMEM_MISALIGN_EN
                m_mis     = (req_addr[1:0] != 2'b00);
`else
                m_mis     = 1'b0;
`endif
            end
        end
        m_cyc++;
    end

    logic [31:0] rd;
    int          lat;
    int          sc;
    bit          err;
    int          n;

    // Issue one request from an IDLE cycle and wait (bounded) for its response
    task automatic txn(input bit w, input logic [31:0] a, input logic [31:0] d);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        #1;
        sc = int'(stall);
        @(posedge clk) #1;
        lat = 1;
        sc += int'(stall);
        req_valid = 1'b0;
        while (!rsp_valid && lat < 50) begin
            @(posedge clk) #1;
            lat++;
            sc += int'(stall);
        end
        if (lat >= 50) chk("txn_timeout", rsp_valid, 1'b1);
        rd  = rsp_rdata;
        err = rsp_err;
        @(posedge clk) #1;
    endtask

    task automatic count_rsp(input int cycles);
        n = 0;
        for (int k = 0; k < cycles; k++) begin
            n += int'(rsp_valid);
            @(posedge clk) #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        @(posedge clk) #1;
        chk_en = 1'b1;
        @(posedge clk) #1;
        reset = 1'b0;
        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_stall", stall, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);

        txn(1'b0, 32'h10, 32'h0);
        chk("load_0x10_after_reset", rd, 32'h0);

        txn(1'b1, 32'h20, 32'hDEADBEEF);
        chk("store_latency", lat, 32'd3);
        chk("store_stall_cycles", sc, 32'd3);
        chk("store_rdata_held", rd, 32'h0);

        txn(1'b0, 32'h20, 32'h0);
        chk("load_0x20", rd, 32'hDEADBEEF);
        chk("load_latency", lat, 32'd3);

        txn(1'b1, 32'h400, 32'h12345678);
        chk("wrap_store_rdata_held", rd, 32'hDEADBEEF);
        txn(1'b0, 32'h0, 32'h0);
        chk("wrap_load_0x0", rd, 32'h12345678);
        txn(1'b0, 32'h20, 32'h0);
        chk("reload_0x20", rd, 32'hDEADBEEF);

`ifdef DMEM_MISALIGN_EN
        txn(1'b0, 32'h22, 32'h0);
        chk("mis_load_rdata", rd, 32'h0);
        chk("mis_load_err", err, 1'b1);
        chk("mis_load_latency", lat, 32'd3);
        txn(1'b1, 32'h21, 32'hFFFFFFFF);
        chk("mis_store_err", err, 1'b1);
        txn(1'b0, 32'h20, 32'h0);
        chk("mis_0x20_unchanged", rd, 32'hDEADBEEF);
        chk("aligned_err_clear", err, 1'b0);
`endif

        // req_valid held high: accepts at 0, 4, 8; responses at 3 and 7 within 10 cycles
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h400;
        count_rsp(10);
        req_valid = 1'b0;
        chk("b2b_rsp_count", n, 32'd2);
        repeat (6) @(posedge clk) #1;
        chk("b2b_rdata", rsp_rdata, 32'h12345678);

        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h30; req_wdata = 32'hAAAA5555;
        @(posedge clk) #1;
        req_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk) #1;
        reset = 1'b0;
        chk("midrst_req_ready", req_ready, 1'b1);
        chk("midrst_rsp_valid", rsp_valid, 1'b0);
        count_rsp(5);
        chk("midrst_no_rsp", n, 32'd0);
        txn(1'b0, 32'h30, 32'h0);
        chk("midrst_load_0x30", rd, 32'h0);
        txn(1'b0, 32'h20, 32'h0);
        chk("midrst_array_cleared", rd, 32'h0);

        reset = 1'b1; req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10;
        @(posedge clk) #1;
        reset = 1'b0; req_valid = 1'b0;
        chk("rst_vs_req_ready", req_ready, 1'b1);
        count_rsp(5);
        chk("rst_vs_req_no_rsp", n, 32'd0);

        repeat (2) @(posedge clk) #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
